bus_arbiter_rr4: RTL
====================

Name: bus_arbiter_rr4

Overview:
- 4-requester round-robin arbiter with hold timeout for the shared internal bus of the 19-bit CPU (register file write port, ALU result bus, memory port).
- Drives a 2-bit owner index into the existing 2-to-4 decoder select, and also provides a one-hot grant directly.
- Sequences ownership: arbitrate, hold the grant until the owner releases it, insert one turnaround cycle, then re-arbitrate.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for one owner before a forced release. Legal range 2..2^CNT_W.
- CNT_W, 4: width of the hold counter.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; level-sensitive; bit i = requester i.
- done  input  1  current owner finished its transfer; sampled only in GRANT.
- grant  output  4  registered one-hot grant; 4'b0000 when no owner.
- grant_idx  output  2  registered owner index; drives the 2-to-4 decoder select.
- busy  output  1  registered; equals |grant.
- timeout  output  1  registered one-cycle pulse on a forced release.

Behaviour:
- Reset (rst=1 at a clock edge):
  - grant=0, grant_idx=0, busy=0, timeout=0.
  - state=IDLE, hold counter=0, last-owner pointer=3, so requester 0 has top priority first.
  - rst has priority over all other inputs, including mid-grant.
- All outputs are registered; there are no combinational input-to-output paths.
- States: IDLE, GRANT, RELEASE.
- Arbitration (IDLE and RELEASE):
  - Scan req starting at (last+1) mod 4, wrapping 3→0; the first set bit wins.
  - Winner w: next cycle state=GRANT, grant=1<<w, grant_idx=w, busy=1, counter=0.
  - If no request: next state=IDLE, grant=0.
- Latency: req seen at edge N in IDLE → grant valid after edge N+1 (1 cycle).
- GRANT (each cycle):
  - Counter increments by 1.
  - Release condition: done=1, OR req[owner]=0, OR counter==MAX_HOLD-1.
  - On release: next state=RELEASE, grant=0, busy=0, last=owner.
  - If the release is caused only by the counter (done=0 and req[owner]=1): timeout=1 during the RELEASE cycle, else timeout=0.
  - done and a req drop in the same cycle produce a single release; timeout=0.
  - Requests from non-owners never preempt the owner.
- Hold limit: an owner keeps grant high for at most MAX_HOLD consecutive cycles.
- RELEASE:
  - Exactly one cycle with grant=0 (bus turnaround).
  - Arbitrates using the updated pointer, so there is exactly one idle cycle between consecutive grants.
  - If the timed-out owner is the only requester, it is re-granted after the gap.
- grant_idx holds the last owner's value while grant=0. It is meaningful only when busy=1.
- done is ignored outside GRANT.
- Invariant: grant is always zero-hot or one-hot, and grant[grant_idx]=1 whenever busy=1.

Test Plan:
1. Hold rst=1 for 2 cycles with req=4'b1111 → grant=0000, busy=0, grant_idx=0, timeout=0. Release rst with req=1111 → grant=0001 one cycle later.
2. Single request: req=0100 at cycle N → grant=0100, grant_idx=2 at N+1; done=1 at N+3 → grant=0000 at N+4; req=0 → stays IDLE, grant=0000.
3. Round robin: req=1111 held, done pulsed in the 2nd cycle of each grant → owners 0,1,2,3,0. Each grant lasts 2 cycles with one 0000 cycle between grants; grant_idx sequence 0,1,2,3,0.
4. Timeout (MAX_HOLD=8): req=0011 held, done=0 → grant=0001 for exactly 8 cycles, then grant=0000 with timeout=1 for one cycle, then grant=0010. With req=0001 only, requester 0 is re-granted after the gap.
5. Owner drop / simultaneous events: grant=0010, then req[1]→0 and done=1 in the same cycle → exactly one RELEASE cycle, timeout=0. Pending req=0100 → granted next.
6. Reset mid-grant: grant=1000 at counter=3, assert rst → grant=0000, busy=0 next edge. Deassert rst with req=1111 → grant=0001, confirming the pointer reset to 3.

Source files
------------

// File: rtl/bus_arbiter_rr4_if.sv
// Request/grant bundle shared by the four bus requesters and the round-robin arbiter.
// The master side drives requests; the slave side (arbiter) returns the grant.
interface bus_arbiter_rr4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output busy,
    output timeout
  );
endinterface

// File: rtl/bus_arbiter_rr4.sv
// Four-way round-robin arbiter for the CPU internal bus with a bounded hold time
// and a one-cycle turnaround between owners; every output is registered.
module bus_arbiter_rr4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  bus_arbiter_rr4_if.slave    bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_param_chk
    $error("bus_arbiter_rr4: MAX_HOLD out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [2:0]       pick;
  logic             owner_req;
  logic             hold_expired;

  // Returns {found, index}: scanning downward from the lowest priority offset
  // leaves the nearest requester after 'last' as the final (winning) assignment.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] c;
    rr_pick = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      c = last + 2'(i);
      if (r[c]) rr_pick = {1'b1, c};
    end
  endfunction

  assign pick         = rr_pick(bus.req, last_q);
  assign owner_req    = bus.req[idx_q];
  assign hold_expired = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE, RELEASE: begin
        if (pick[2]) begin
          state_d = GRANT;
          grant_d = 4'b0001 << pick[1:0];
          idx_d   = pick[1:0];
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          grant_d = 4'b0000;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.done || !owner_req || hold_expired) begin
          state_d   = RELEASE;
          grant_d   = 4'b0000;
          last_d    = idx_q;
          // Forced release only when the owner still wants the bus.
          timeout_d = !bus.done && owner_req;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase

    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 2'd3;
      grant_q   <= 4'b0000;
      idx_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;

endmodule
